// File: rtl/blowfish_encrypt_iter.sv
// Iterative Blowfish-style block encryptor.
// The key schedule and S-boxes are simplified: subkeys are P[i] ^ key word, and each S-box is a
// fixed XOR pattern.
// One Feistel round runs per clock: accept, 16 rounds, a final whitening cycle, then the result
// is held until it is taken.
module blowfish_encrypt_iter (
  input  logic         clock,
  input  logic         reset,
  input  logic [63:0]  plaintext,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [63:0]  ciphertext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  localparam logic [31:0] PArray [18] = '{
    32'h243f6a88, 32'h85a308d3, 32'h13198a2e, 32'h03707344, 32'ha4093822, 32'h299f31d0,
    32'h082efa98, 32'hec4e6c89, 32'h452821e6, 32'h38d01377, 32'hbe5466cf, 32'h34e90c6c,
    32'hc0ac29b7, 32'hc97c50dd, 32'h3f84d5b5, 32'hb5470917, 32'h9216d5d9, 32'h8979fb1b
  };

  state_e         state_q, state_d;
  logic [31:0]    xl_q, xl_d, xr_q, xr_d;
  logic [3:0]     r_q, r_d;
  logic [127:0]   key_q, key_d;
  logic [63:0]    ct_q, ct_d;
  logic           ov_q, ov_d;
  logic [31:0]    t, f_t;

  // Word 0 is the most significant 32 bits of the key.
  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = k[127:96];
      2'd1:    w = k[95:64];
      2'd2:    w = k[63:32];
      default: w = k[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [31:0] subkey(input logic [4:0] idx, input logic [127:0] k);
    return PArray[idx] ^ key_word(k, idx[1:0]);
  endfunction

  // S-boxes are constant XOR patterns, so no lookup tables are needed.
  function automatic logic [31:0] f_round(input logic [31:0] x);
    logic [31:0] s1, s2, s3, s4;
    s1 = {24'h0, x[31:24]} ^ 32'h243f6a88;
    s2 = {24'h0, x[23:16]} ^ 32'h85a308d3;
    s3 = {24'h0, x[15:8]}  ^ 32'h13198a2e;
    s4 = {24'h0, x[7:0]}   ^ 32'h03707344;
    return ((s1 + s2) ^ s3) + s4;
  endfunction

  assign t   = xl_q ^ subkey({1'b0, r_q}, key_q);
  assign f_t = f_round(t);

  // Next-state and datapath update for the accept / round / final / hold sequence.
  always_comb begin
    state_d = state_q;
    xl_d    = xl_q;
    xr_d    = xr_q;
    r_d     = r_q;
    key_d   = key_q;
    ct_d    = ct_q;
    ov_d    = ov_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          xl_d    = plaintext[63:32];
          xr_d    = plaintext[31:0];
          key_d   = key;
          r_d     = 4'd0;
          state_d = StRound;
        end
      end
      StRound: begin
        xl_d = xr_q ^ f_t;
        xr_d = t;
        r_d  = r_q + 4'd1;
        if (r_q == 4'd15) state_d = StFinal;
      end
      StFinal: begin
        ct_d    = {xr_q ^ subkey(5'd17, key_q), xl_q ^ subkey(5'd16, key_q)};
        ov_d    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset that clears everything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      xl_q    <= 32'h0;
      xr_q    <= 32'h0;
      r_q     <= 4'd0;
      key_q   <= 128'h0;
      ct_q    <= 64'h0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      xl_q    <= xl_d;
      xr_q    <= xr_d;
      r_q     <= r_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q == StRound) || (state_q == StFinal);
  assign ciphertext = ct_q;
  assign out_valid  = ov_q;

endmodule

// File: tb/tb_blowfish_encrypt_iter.sv
// Self-checking bench for blowfish_encrypt_iter with a textbook-form Feistel reference model.
module tb_blowfish_encrypt_iter;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [63:0]  plaintext = 64'h0;
  logic [127:0] key = 128'h0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  ciphertext;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] PTab [18] = '{
    32'h243f6a88, 32'h85a308d3, 32'h13198a2e, 32'h03707344, 32'ha4093822, 32'h299f31d0,
    32'h082efa98, 32'hec4e6c89, 32'h452821e6, 32'h38d01377, 32'hbe5466cf, 32'h34e90c6c,
    32'hc0ac29b7, 32'hc97c50dd, 32'h3f84d5b5, 32'hb5470917, 32'h9216d5d9, 32'h8979fb1b
  };
  localparam logic [31:0] SMask [4] = '{32'h243f6a88, 32'h85a308d3, 32'h13198a2e, 32'h03707344};

  blowfish_encrypt_iter dut (
    .clock      (clock),
    .reset      (reset),
    .plaintext  (plaintext),
    .key        (key),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_sbox(input int n, input logic [7:0] a);
    return {24'h0, a} ^ SMask[n];
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] x);
    return ((m_sbox(0, x[31:24]) + m_sbox(1, x[23:16])) ^ m_sbox(2, x[15:8])) + m_sbox(3, x[7:0]);
  endfunction

  function automatic logic [31:0] m_k(input int i, input logic [127:0] k);
    return PTab[i] ^ k[127 - 32 * (i % 4) -: 32];
  endfunction

  // Textbook form: L ^= P, R ^= F(L), swap; undo the last swap; whiten.
  function automatic logic [63:0] model(input logic [63:0] pt, input logic [127:0] k);
    logic [31:0] l, r, tmp;
    l = pt[63:32];
    r = pt[31:0];
    for (int i = 0; i < 16; i++) begin
      l = l ^ m_k(i, k);
      r = r ^ m_f(l);
      tmp = l; l = r; r = tmp;
    end
    tmp = l; l = r; r = tmp;
    r = r ^ m_k(16, k);
    l = l ^ m_k(17, k);
    return {l, r};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Accepts one block, scrambles the inputs afterwards, and waits (bounded) for out_valid.
  task automatic run_block(input logic [63:0] pt, input logic [127:0] k,
                           output logic [63:0] ct, output int lat);
    plaintext = pt;
    key       = k;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    plaintext = {$urandom, $urandom};
    key       = {$urandom, $urandom, $urandom, $urandom};
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    ct = ciphertext;
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (ciphertext !== 64'h0) begin errors++;
      $display("FAIL reset_ct got=%h exp=0", ciphertext); end
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_ov got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_latency;
    logic [63:0] ct, exp;
    int lat;
    exp = model(64'h0123456789ABCDEF, 128'h0);
    run_block(64'h0123456789ABCDEF, 128'h0, ct, lat);
    checks++; if (lat != 17) begin errors++;
      $display("FAIL latency got=%0d exp=17", lat); end
    checks++; if (ct !== exp) begin errors++;
      $display("FAIL latency_ct got=%h exp=%h", ct, exp); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL done_busy got=%b exp=0", busy); end
    handshake();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL latency_release got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure;
    logic [63:0] ct, exp, pt;
    logic [127:0] k;
    int lat;
    pt  = {$urandom, $urandom};
    k   = {$urandom, $urandom, $urandom, $urandom};
    exp = model(pt, k);
    run_block(pt, k, ct, lat);
    checks++; if (lat != 17 || ct !== exp) begin errors++;
      $display("FAIL bp_block got lat=%0d ct=%h exp lat=17 ct=%h", lat, ct, exp); end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      tick();
      checks++; if (out_valid !== 1'b1 || ciphertext !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got ov=%b ct=%h rdy=%b exp ov=1 ct=%h rdy=0",
                 i, out_valid, ciphertext, in_ready, exp);
      end
    end
    in_valid = 1'b0;
    handshake();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready); end
    checks++; if (ciphertext !== exp) begin errors++;
      $display("FAIL bp_ct_retained got=%h exp=%h", ciphertext, exp); end
    tick();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_ignored_pulse got busy=%b rdy=%b exp busy=0 rdy=1", busy, in_ready); end
  endtask

  task automatic test_key_sensitivity;
    logic [63:0] ct0, ct1, e0, e1, pt;
    logic [127:0] k1;
    int lat;
    pt = 64'h0123456789ABCDEF;
    k1 = 128'h00000001_00000000_00000000_00000000;
    e0 = model(pt, 128'h0);
    e1 = model(pt, k1);
    run_block(pt, 128'h0, ct0, lat);
    handshake();
    checks++; if (ct0 !== e0) begin errors++;
      $display("FAIL key0_ct got=%h exp=%h", ct0, e0); end
    run_block(pt, k1, ct1, lat);
    handshake();
    checks++; if (ct1 !== e1) begin errors++;
      $display("FAIL key1_ct got=%h exp=%h", ct1, e1); end
    checks++; if (ct0 === ct1) begin errors++;
      $display("FAIL key_differ got equal=%h exp different", ct0); end
  endtask

  task automatic test_random;
    logic [63:0] ct, exp, pt;
    logic [127:0] k;
    int lat;
    for (int n = 0; n < 4; n++) begin
      pt  = {$urandom, $urandom};
      k   = {$urandom, $urandom, $urandom, $urandom};
      exp = model(pt, k);
      run_block(pt, k, ct, lat);
      handshake();
      checks++; if (lat != 17 || ct !== exp) begin errors++;
        $display("FAIL random[%0d] got lat=%0d ct=%h exp lat=17 ct=%h", n, lat, ct, exp); end
    end
  endtask

  task automatic test_mid_reset;
    logic [63:0] ct, exp, pt;
    logic [127:0] k;
    int lat;
    plaintext = {$urandom, $urandom};
    key       = {$urandom, $urandom, $urandom, $urandom};
    in_valid  = 1'b1;
    tick();  // E0
    in_valid  = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    reset = 1'b0;
    tick();  // E8
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || ciphertext !== 64'h0) begin errors++;
      $display("FAIL mid_reset got busy=%b ov=%b ct=%h exp 0 0 0", busy, out_valid, ciphertext);
    end
    reset = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
      $display("FAIL mid_reset_release got rdy=%b ov=%b exp rdy=1 ov=0", in_ready, out_valid); end
    pt  = {$urandom, $urandom};
    k   = {$urandom, $urandom, $urandom, $urandom};
    exp = model(pt, k);
    run_block(pt, k, ct, lat);
    handshake();
    checks++; if (lat != 17 || ct !== exp) begin errors++;
      $display("FAIL after_reset got lat=%0d ct=%h exp lat=17 ct=%h", lat, ct, exp); end
  endtask

  task automatic test_back_to_back;
    int acc_edges[$];
    logic [63:0] pq[$];
    logic [63:0] pt, exp, p;
    logic [127:0] k;
    int outs;
    k         = {$urandom, $urandom, $urandom, $urandom};
    pt        = {$urandom, $urandom};
    key       = k;
    plaintext = pt;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    outs      = 0;
    for (int e = 0; e < 80 && outs < 3; e++) begin
      automatic logic acc = in_ready && in_valid;
      tick();
      if (acc) begin
        acc_edges.push_back(e);
        pq.push_back(pt);
        pt = {$urandom, $urandom};
        plaintext = pt;
      end
      if (out_valid) begin
        outs++;
        p = (pq.size() > 0) ? pq.pop_front() : 64'h0;
        exp = model(p, k);
        checks++; if (ciphertext !== exp) begin errors++;
          $display("FAIL b2b_ct[%0d] got=%h exp=%h", outs, ciphertext, exp); end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (outs != 3) begin errors++;
      $display("FAIL b2b_outputs got=%0d exp=3", outs); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc_edges.size() <= i || acc_edges[i] != 19 * i) begin
        errors++;
        $display("FAIL b2b_accept_edge[%0d] got=%0d exp=%0d", i,
                 (acc_edges.size() > i) ? acc_edges[i] : -1, 19 * i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_key_sensitivity();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
